uart_midi_tx: RTL and testbench

Serial MIDI transmitter: accepts one packed MIDI event per handshake and serializes it as standard 8N1 UART frames on a single output line, LSB first. It is the transmit-side counterpart of `uart_midi_rx`, runs on the 98.3 MHz audio clock, and drives `uart_txd` so the design can echo or forward MIDI to an external synth or host. Message length comes from the status byte, and invalid events are dropped.

---
 rtl/uart_midi_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_midi_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_midi_tx.sv
// uart_midi_tx: serial MIDI transmitter.
// Accepts one packed MIDI event {status, data1, data2} per valid/ready handshake.
// Sends the bytes the status implies as 8N1 UART frames, LSB first.
// Data bytes have bit 7 cleared. Invalid events are consumed without line activity.
// Optional feature macro: MIDI_RUNNING_STATUS_EN. When it is defined, the status
// byte is omitted when it repeats the last channel-voice status that was sent.
module uart_midi_tx #(
  parameter int unsigned CLK_HZ = 98_333_333,
  parameter int unsigned BAUD   = 31_250
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [23:0] midi_bytes_in,
  output logic        ready_out,
  output logic        tx_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Number of bytes a status byte implies; 0 marks an invalid event.
  function automatic logic [1:0] midi_len(input logic [7:0] st);
    logic [1:0] n;
    n = 2'd0;
    case (st[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd3;
      4'hC, 4'hD:                   n = 2'd2;
      4'hF:                         n = st[3] ? 2'd1 : 2'd0;
      default:                      n = 2'd0;
    endcase
    return n;
  endfunction

`ifdef MIDI_RUNNING_STATUS_EN
  // Channel-voice status bytes 0x80..0xEF take part in running status.
  function automatic logic is_voice(input logic [7:0] st);
    return (st[7] == 1'b1) && (st[7:4] != 4'hF);
  endfunction
`endif

  state_t           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [1:0]       byte_idx_r;
  logic [1:0]       byte_cnt_r;
  logic [7:0]       byte0_r, byte1_r, byte2_r;
  logic             tx_r, ready_r, busy_r, done_r;

  logic [7:0] status_s, d1_s, d2_s;
  logic [7:0] b0_s, b1_s, b2_s;
  logic [1:0] len_s, cnt_s;
  logic [7:0] cur_byte_s;
  logic       accept_s;
  logic       bit_end_s;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_r;
`endif

  // Turn the presented event into the ordered list of bytes to transmit.
  always_comb begin
    status_s = midi_bytes_in[23:16];
    d1_s     = midi_bytes_in[15:8] & 8'h7F;
    d2_s     = midi_bytes_in[7:0] & 8'h7F;
    len_s    = midi_len(status_s);
    b0_s     = status_s;
    b1_s     = d1_s;
    b2_s     = d2_s;
    cnt_s    = len_s;
`ifdef MIDI_RUNNING_STATUS_EN
    if (is_voice(status_s) && (status_s == last_status_r)) begin
      b0_s  = d1_s;
      b1_s  = d2_s;
      b2_s  = 8'h00;
      cnt_s = len_s - 2'd1;
    end else begin
      cnt_s = len_s;
    end
`endif
  end

  // Handshake decode and end-of-bit detection.
  always_comb begin
    accept_s  = valid_in && ready_r && (state_r == ST_IDLE) && (len_s != 2'd0);
    bit_end_s = (baud_cnt_r == CNT_LAST);
  end

  // Select the byte currently being framed.
  always_comb begin
    cur_byte_s = byte0_r;
    case (byte_idx_r)
      2'd0:    cur_byte_s = byte0_r;
      2'd1:    cur_byte_s = byte1_r;
      2'd2:    cur_byte_s = byte2_r;
      default: cur_byte_s = byte0_r;
    endcase
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit, per byte.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      byte_cnt_r <= 2'd0;
      byte0_r    <= 8'h00;
      byte1_r    <= 8'h00;
      byte2_r    <= 8'h00;
      tx_r       <= 1'b1;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          baud_cnt_r <= '0;
          bit_idx_r  <= 3'd0;
          byte_idx_r <= 2'd0;
          if (accept_s) begin
            byte0_r    <= b0_s;
            byte1_r    <= b1_s;
            byte2_r    <= b2_s;
            byte_cnt_r <= cnt_s;
            state_r    <= ST_START;
            tx_r       <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            tx_r       <= cur_byte_s[0];
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if ((byte_idx_r + 2'd1) < byte_cnt_r) begin
              // Next byte follows the stop bit directly.
              byte_idx_r <= byte_idx_r + 2'd1;
              tx_r       <= 1'b0;
              state_r    <= ST_START;
            end else begin
              byte_idx_r <= 2'd0;
              tx_r       <= 1'b1;
              done_r     <= 1'b1;
              ready_r    <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          baud_cnt_r <= '0;
          tx_r       <= 1'b1;
          ready_r    <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  // Track the last channel-voice status that went out on the line.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      last_status_r <= 8'h00;
    end else if (accept_s && is_voice(status_s)) begin
      last_status_r <= status_s;
    end else begin
      last_status_r <= last_status_r;
    end
  end
`endif

  assign tx_out    = tx_r;
  assign ready_out = ready_r;
  assign busy_out  = busy_r;
  assign done_out  = done_r;

endmodule

// File: tb/tb_uart_midi_tx.sv
// Self-checking bench for uart_midi_tx with a scaled baud divisor (8 clocks/bit).
// The reference model expands each event into its byte list and line bit sequence.
module tb_uart_midi_tx;

  localparam int unsigned TB_CLK_HZ = 1000;
  localparam int unsigned TB_BAUD   = 125;
  localparam int DIV = TB_CLK_HZ / TB_BAUD;

  logic        clk_in;
  logic        rst_in;
  logic        valid_in;
  logic [23:0] midi_bytes_in;
  logic        ready_out;
  logic        tx_out;
  logic        busy_out;
  logic        done_out;

  int checks   = 0;
  int failures = 0;

  bit         exp_bits[$];
  logic [7:0] last_status_m = 8'h00;

  uart_midi_tx #(.CLK_HZ(TB_CLK_HZ), .BAUD(TB_BAUD)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .valid_in(valid_in),
    .midi_bytes_in(midi_bytes_in),
    .ready_out(ready_out),
    .tx_out(tx_out),
    .busy_out(busy_out),
    .done_out(done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: event -> byte list -> line bits (start, 8 LSB-first, stop).
  task automatic build_frame(input logic [23:0] ev, output int nbytes);
    logic [7:0] st, d1, d2;
    logic [7:0] msg[$];
    st  = ev[23:16];
    d1  = ev[15:8] % 8'd128;
    d2  = ev[7:0] % 8'd128;
    msg = {};
    if ((st >= 8'h80 && st <= 8'hBF) || (st >= 8'hE0 && st <= 8'hEF)) msg = {st, d1, d2};
    else if (st >= 8'hC0 && st <= 8'hDF) msg = {st, d1};
    else if (st >= 8'hF8) msg = {st};
`ifdef MIDI_RUNNING_STATUS_EN
    if (st >= 8'h80 && st <= 8'hEF) begin
      if (st == last_status_m) void'(msg.pop_front());
      else last_status_m = st;
    end
`endif
    exp_bits = {};
    foreach (msg[i]) begin
      exp_bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_bits.push_back(msg[i][b]);
      exp_bits.push_back(1'b1);
    end
    nbytes = msg.size();
  endtask

  // Compare the line cycle by cycle against the expected bit sequence.
  task automatic watch(input int ncycles, input string tag);
    for (int k = 0; k < ncycles; k++) begin
      chk({tag, ":tx"}, tx_out, exp_bits[k / DIV]);
      chk({tag, ":busy"}, busy_out, 1'b1);
      chk({tag, ":done_early"}, done_out, 1'b0);
      @(posedge clk_in); #1;
    end
  endtask

  // Present one event, then check the whole message and its completion.
  task automatic xmit(input logic [23:0] ev, input bit hold, input logic [23:0] next_ev,
                      input string tag);
    int nb;
    build_frame(ev, nb);
    valid_in      = 1'b1;
    midi_bytes_in = ev;
    chk({tag, ":ready_pre"}, ready_out, 1'b1);
    @(posedge clk_in); #1;
    if (hold) begin
      midi_bytes_in = next_ev;
    end else begin
      valid_in      = 1'b0;
      midi_bytes_in = 24'($urandom);
    end
    if (nb == 0) begin
      for (int k = 0; k < 3; k++) begin
        chk({tag, ":inv_tx"}, tx_out, 1'b1);
        chk({tag, ":inv_busy"}, busy_out, 1'b0);
        chk({tag, ":inv_ready"}, ready_out, 1'b1);
        chk({tag, ":inv_done"}, done_out, 1'b0);
        @(posedge clk_in); #1;
      end
    end else begin
      watch(nb * 10 * DIV, tag);
      chk({tag, ":done"}, done_out, 1'b1);
      chk({tag, ":ready_done"}, ready_out, 1'b1);
      chk({tag, ":busy_done"}, busy_out, 1'b0);
      chk({tag, ":tx_done"}, tx_out, 1'b1);
    end
  endtask

  task automatic idle_check(input string tag);
    valid_in = 1'b0;
    @(posedge clk_in); #1;
    chk({tag, ":idle_done"}, done_out, 1'b0);
    chk({tag, ":idle_tx"}, tx_out, 1'b1);
    chk({tag, ":idle_ready"}, ready_out, 1'b1);
    chk({tag, ":idle_busy"}, busy_out, 1'b0);
  endtask

  initial begin
    int nb;
    logic [7:0] st;
    logic [7:0] prev_st;
    rst_in        = 1'b0;
    valid_in      = 1'b0;
    midi_bytes_in = 24'h000000;
    prev_st       = 8'h90;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tx", tx_out, 1'b1);
    chk("rst_ready", ready_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_done", done_out, 1'b0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rel_ready", ready_out, 1'b1);
    chk("rel_tx", tx_out, 1'b1);

    // Directed messages
    xmit(24'h903C64, 1'b0, 24'h0, "note_on");
    idle_check("note_on");
    xmit(24'hC507AA, 1'b0, 24'h0, "prog_chg");
    idle_check("prog_chg");
    xmit(24'hF81234, 1'b0, 24'h0, "realtime");
    idle_check("realtime");
    xmit(24'h451234, 1'b0, 24'h0, "inv_data");
    xmit(24'hF05566, 1'b0, 24'h0, "inv_sysex");
    xmit(24'h80FF81, 1'b0, 24'h0, "mask");
    idle_check("mask");

    // Back-to-back with valid held between messages
    xmit(24'h903C64, 1'b1, 24'h904000, "b2b_first");
    xmit(24'h904000, 1'b0, 24'h0, "b2b_second");
    idle_check("b2b");

    // Randomized events across every status class
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 5))
        0:       st = 8'($urandom_range(0, 127));
        1:       st = 8'($urandom_range(128, 239));
        2:       st = 8'($urandom_range(192, 223));
        3:       st = 8'($urandom_range(240, 247));
        4:       st = 8'($urandom_range(248, 255));
        default: st = prev_st;
      endcase
      if (st >= 8'h80 && st <= 8'hEF) prev_st = st;
      xmit({st, 8'($urandom), 8'($urandom)}, 1'b0, 24'h0, "rand");
    end
    idle_check("rand");

    // Reset during the data bits of the second byte
    build_frame(24'h903C64, nb);
    valid_in      = 1'b1;
    midi_bytes_in = 24'h903C64;
    chk("abort:ready_pre", ready_out, 1'b1);
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    watch(10 * DIV + 2 * DIV + 3, "abort");
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    last_status_m = 8'h00;
    chk("abort:tx", tx_out, 1'b1);
    chk("abort:busy", busy_out, 1'b0);
    chk("abort:done", done_out, 1'b0);
    chk("abort:ready", ready_out, 1'b0);
    @(posedge clk_in); #1;
    chk("abort:done_hold", done_out, 1'b0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("abort:ready_rel", ready_out, 1'b1);
    chk("abort:done_rel", done_out, 1'b0);
    xmit(24'h903C64, 1'b0, 24'h0, "after_rst");
    idle_check("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
